// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: FSM states, BCD digit vector, 7-seg codes and load clamp; STOPWATCH_COUNTDOWN_EN adds S_EXPIRED
package stopwatch_pkg;
`ifdef STOPWATCH_COUNTDOWN_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
`endif
  typedef logic [3:0][3:0] bcd_t;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = SEG_0;
      4'd1: seg7 = SEG_1;
      4'd2: seg7 = SEG_2;
      4'd3: seg7 = SEG_3;
      4'd4: seg7 = SEG_4;
      4'd5: seg7 = SEG_5;
      4'd6: seg7 = SEG_6;
      4'd7: seg7 = SEG_7;
      4'd8: seg7 = SEG_8;
      4'd9: seg7 = SEG_9;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  function automatic bcd_t clamp_bcd(input bcd_t v, input logic [3:0] max_mt, input logic [3:0] max_mu);
    bcd_t c;
    for (int i = 0; i < 4; i++) c[i] = v[i] > 4'd9 ? 4'd9 : v[i];
    if (c[1] > 4'd5) c[1:0] = {4'd5, 4'd9};
    if (c[3] > max_mt || (c[3] == max_mt && c[2] > max_mu)) c[3:2] = {max_mt, max_mu};
    return c;
  endfunction
endpackage

// File: rtl/stopwatch_timer_bcd_tick_divider.sv
// tick_divider: one-cycle tick every CLK_HZ/TICK_HZ enabled clocks; holds while disabled
module tick_divider #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == W'(DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (restart) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/stopwatch_timer_bcd.sv
// stopwatch_timer_bcd: mm:ss BCD stopwatch with 7-seg output; STOPWATCH_COUNTDOWN_EN enables load, countdown and EXPIRED
module stopwatch_timer_bcd
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1,
  parameter int MAX_MIN = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        mode_down,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] bcd,
  output logic [27:0] seg,
  output logic        running,
  output logic        led,
  output logic        wrap,
  output logic        expired
);
  localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MU = 4'(MAX_MIN % 10);
  state_t state, state_n;
  bcd_t cnt, cnt_n, inc, cnt_step;
  logic dir_down, tick, restart, load_acc, start_ok, s_top, at_max;

  tick_divider #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_div (
    .clk,
    .rst,
    .enable(state == S_RUN),
    .restart,
    .tick
  );

  assign start_ok = state == S_IDLE && start_stop && !clear && !load_acc;
  assign restart = state == S_IDLE && state_n == S_RUN;

  always_comb begin
    s_top = cnt[1:0] == 8'h59;
    at_max = s_top && cnt[3:2] == {MAX_MT, MAX_MU};
    inc = cnt;
    inc[0] = cnt[0] == 4'd9 ? 4'd0 : cnt[0] + 4'd1;
    if (cnt[0] == 4'd9) inc[1] = cnt[1] == 4'd5 ? 4'd0 : cnt[1] + 4'd1;
    if (s_top) inc[3:2] = cnt[2] == 4'd9 ? {cnt[3] + 4'd1, 4'd0} : {cnt[3], cnt[2] + 4'd1};
    if (at_max) inc = '0;
  end

`ifdef STOPWATCH_COUNTDOWN_EN
  bcd_t dec;
  logic s_bot, hit_zero;
  always_comb begin
    s_bot = cnt[1:0] == 8'h00;
    dec = cnt;
    dec[0] = cnt[0] == 4'd0 ? 4'd9 : cnt[0] - 4'd1;
    if (cnt[0] == 4'd0) dec[1] = cnt[1] == 4'd0 ? 4'd5 : cnt[1] - 4'd1;
    if (s_bot) dec[3:2] = cnt[2] == 4'd0 ? {cnt[3] - 4'd1, 4'd9} : {cnt[3], cnt[2] - 4'd1};
  end
  assign hit_zero = dec == '0;
  assign cnt_step = dir_down ? dec : inc;
  assign load_acc = load && state == S_IDLE;
  assign expired = state == S_EXPIRED;
  always_ff @(posedge clk or posedge rst)
    if (rst) dir_down <= 1'b0;
    else if (start_ok) dir_down <= mode_down;
`else
  logic unused_in;
  assign unused_in = ^{mode_down, load, load_val};
  assign cnt_step = inc;
  assign load_acc = 1'b0;
  assign dir_down = 1'b0;
  assign expired = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_ok) state_n = S_RUN;
      S_RUN:   if (start_stop) state_n = S_PAUSE;
      S_PAUSE: if (start_stop) state_n = S_RUN;
      default: state_n = state;
    endcase
`ifdef STOPWATCH_COUNTDOWN_EN
    if (start_ok && mode_down && cnt == '0) state_n = S_EXPIRED;
    if (state == S_RUN && tick && dir_down && hit_zero) state_n = S_EXPIRED;
    if (state == S_EXPIRED && start_stop) state_n = S_IDLE;
`endif
    if (clear) state_n = S_IDLE;
  end

  assign cnt_n = clear ? '0 : load_acc ? clamp_bcd(load_val, MAX_MT, MAX_MU) : tick ? cnt_step : cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      led <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      led <= !clear && (led ^ tick);
      wrap <= !clear && tick && !dir_down && at_max;
    end

  assign bcd = cnt;
  assign seg = {seg7(cnt[3]), seg7(cnt[2]), seg7(cnt[1]), seg7(cnt[0])};
  assign running = state == S_RUN;
endmodule

// File: tb/tb_stopwatch_timer_bcd.sv
// tb_stopwatch_timer_bcd: scoreboarded random and directed bench against a seconds-based reference model
module tb_stopwatch_timer_bcd;
  localparam int DIV = 4;
  localparam int MAXS = 59 * 60 + 59;
`ifdef STOPWATCH_COUNTDOWN_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start_stop = 1'b0, clear = 1'b0, mode_down = 1'b0, load = 1'b0;
  logic [15:0] load_val = '0, bcd;
  logic [27:0] seg;
  logic running, led, wrap, expired;

  stopwatch_timer_bcd #(.CLK_HZ(4), .TICK_HZ(1), .MAX_MIN(59)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .mode_down(mode_down),
    .load(load), .load_val(load_val), .bcd(bcd), .seg(seg), .running(running),
    .led(led), .wrap(wrap), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic [27:0] seg;
    logic running, led, wrap, expired;
  } obs_t;
  obs_t exp_q[$];
  int total = 0, bad = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int m_st = 0;
  int m_secs = 0, m_run_clks = 0;
  bit m_down = 0, m_led = 0, m_wrap = 0;

  function automatic logic [15:0] to_bcd(input int s);
    int mn, sc;
    mn = s / 60;
    sc = s % 60;
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic int clamp_secs(input logic [15:0] v);
    int d[4];
    int mn, sc;
    for (int i = 0; i < 4; i++) begin
      d[i] = int'(v[i*4 +: 4]);
      if (d[i] > 9) d[i] = 9;
    end
    sc = d[1] * 10 + d[0];
    mn = d[3] * 10 + d[2];
    if (sc > 59) sc = 59;
    if (mn > 59) mn = 59;
    return mn * 60 + sc;
  endfunction

  function automatic obs_t exp_obs();
    obs_t o;
    logic [15:0] b;
    b = to_bcd(m_secs);
    o.bcd = b;
    o.seg = {seg_tab[b[15:12]], seg_tab[b[11:8]], seg_tab[b[7:4]], seg_tab[b[3:0]]};
    o.running = m_st == 1;
    o.led = m_led;
    o.wrap = m_wrap;
    o.expired = m_st == 3;
    return o;
  endfunction

  // states: 0 idle, 1 run, 2 pause, 3 expired
  function automatic void model_step(input bit r, ss, cl, md, ld, input logic [15:0] lv);
    bit tick;
    if (r) begin
      m_st = 0; m_secs = 0; m_run_clks = 0; m_down = 0; m_led = 0; m_wrap = 0;
      return;
    end
    tick = m_st == 1 && m_run_clks % DIV == DIV - 1;
    if (m_st == 1) m_run_clks++;
    m_wrap = 0;
    if (cl) begin
      m_st = 0; m_secs = 0; m_led = 0;
      return;
    end
    if (tick) begin
      m_led = !m_led;
      if (m_down) m_secs--;
      else if (m_secs == MAXS) begin m_secs = 0; m_wrap = 1; end
      else m_secs++;
    end
    if (CD && ld && m_st == 0) m_secs = clamp_secs(lv);
    else if (tick && m_down && m_secs == 0) m_st = 3;
    else if (ss) begin
      case (m_st)
        0: begin
          m_down = CD && md;
          if (m_down && m_secs == 0) m_st = 3;
          else begin m_st = 1; m_run_clks = 0; end
        end
        1: m_st = 2;
        2: m_st = 1;
        default: m_st = 0;
      endcase
    end
  endfunction

  task automatic step(input bit r, ss, cl, md, ld, input logic [15:0] lv);
    @(negedge clk);
    rst = r; start_stop = ss; clear = cl; mode_down = md; load = ld; load_val = lv;
    model_step(r, ss, cl, md, ld, lv);
    exp_q.push_back(exp_obs());
    @(posedge clk);
    #2;
    start_stop = 0; clear = 0; load = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic point(input string nm, input logic [15:0] eb, input logic er, el, ew, ee);
    total++;
    if ({bcd, running, led, wrap, expired} !== {eb, er, el, ew, ee}) begin
      bad++;
      $display("FAIL %s: got bcd=%h run=%b led=%b wrap=%b exp=%b, want bcd=%h run=%b led=%b wrap=%b exp=%b",
               nm, bcd, running, led, wrap, expired, eb, er, el, ew, ee);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = {bcd, seg, running, led, wrap, expired};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t: got bcd=%h seg=%h run=%b led=%b wrap=%b exp=%b, want bcd=%h seg=%h run=%b led=%b wrap=%b exp=%b",
                 $time, a.bcd, a.seg, a.running, a.led, a.wrap, a.expired,
                 e.bcd, e.seg, e.running, e.led, e.wrap, e.expired);
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 0, 16'h0);
    point("reset", 16'h0000, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 0, 0, 16'h0);
    idle(240);
    point("up_240", 16'h0100, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 16'h0);
    point("clear", 16'h0000, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 16'h0);
    idle(5);
    step(0, 1, 0, 0, 0, 16'h0);
    point("paused", 16'h0001, 0, 1, 0, 0);
    idle(20);
    point("pause_hold", 16'h0001, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 16'h0);
    idle(1);
    point("resume_1", 16'h0001, 1, 1, 0, 0);
    idle(1);
    point("resume_2", 16'h0002, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 16'h1234);
    point("priority", 16'h0000, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 16'h0);
    idle(9);
    step(1, 0, 0, 0, 0, 16'h0);
    point("rst_mid", 16'h0000, 0, 0, 0, 0);
    idle(12);
    point("post_rst", 16'h0000, 0, 0, 0, 0);
`ifdef STOPWATCH_COUNTDOWN_EN
    step(0, 0, 0, 0, 1, 16'h0002);
    point("load2", 16'h0002, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 16'h0);
    idle(4);
    point("down1", 16'h0001, 1, 1, 0, 0);
    idle(4);
    point("expired", 16'h0000, 0, 0, 0, 1);
    idle(3);
    point("exp_hold", 16'h0000, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 16'h0);
    point("exp_to_idle", 16'h0000, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 16'h0);
    point("zero_start", 16'h0000, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 16'h0);
    step(0, 0, 0, 0, 1, 16'h9A75);
    point("clamp", 16'h5959, 0, 0, 0, 0);
`else
    step(0, 0, 0, 1, 1, 16'h9A75);
    point("load_ignored", 16'h0000, 0, 0, 0, 0);
`endif
    step(0, 0, 1, 0, 0, 16'h0);
    step(0, 1, 0, 0, 0, 16'h0);
    idle(14396);
    point("at_5959", 16'h5959, 1, 1, 0, 0);
    idle(3);
    point("pre_wrap", 16'h5959, 1, 1, 0, 0);
    idle(1);
    point("wrap", 16'h0000, 1, 0, 1, 0);
    idle(1);
    point("wrap_end", 16'h0000, 1, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 499) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, 16'($urandom));
    repeat (4) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
